song_addr_ctrl: RTL and testbench

SONG_ADDR_CTRL -- requirements
Module: song_addr_ctrl

---
 rtl/song_addr_ctrl.sv | 156 +++++++++++++++
 tb/tb_song_addr_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/song_addr_ctrl.sv
// Song playback address controller: issues one flash byte fetch per audio sample tick,
// steps the address forward or backward with wrap, and flags overruns and fetch timeouts.
module song_addr_ctrl #(
  parameter logic [22:0] START_ADDR = 23'h000000,
  parameter logic [22:0] END_ADDR   = 23'h07FFFF,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic        play,
  input  logic        forward,
  input  logic        restart,
  input  logic        byte_done,
  output logic        ready,
  output logic [22:0] flash_address,
  output logic        busy,
  output logic        wrap,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_ADVANCE   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_timeout_hit;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic [22:0]   r_addr;
  logic [22:0]   w_start;
  logic          r_pend;
  logic          r_ready;
  logic          r_busy;
  logic          r_wrap;
  logic          r_overrun;
  logic          r_timeout_err;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_start   = forward ? START_ADDR : END_ADDR;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; byte_done wins over a timeout landing in the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sample_tick && play) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (byte_done) begin
          w_state_nxt = S_ADVANCE;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_state_nxt   = S_ADVANCE;
          w_timeout_hit = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_ADVANCE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: address, pending restart, timeout counter and registered flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= START_ADDR;
      r_pend        <= 1'b0;
      r_cnt         <= '0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_wrap        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_ISSUE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_wrap  <= 1'b0;
      if (sample_tick && r_busy) begin
        r_overrun <= 1'b1;
      end
      if (w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_DONE) begin
        r_cnt <= w_cnt_inc;
      end
      case (r_state)
        S_IDLE: begin
          if (restart) begin
            r_addr <= w_start;
          end
        end
        S_ISSUE, S_WAIT_DONE: begin
          if (restart) begin
            r_pend <= 1'b1;
          end
        end
        S_ADVANCE: begin
          // A pending restart replaces the step and never reports a wrap
          if (r_pend || restart) begin
            r_addr <= w_start;
            r_pend <= 1'b0;
          end else if (forward) begin
            if (r_addr == END_ADDR) begin
              r_addr <= START_ADDR;
              r_wrap <= 1'b1;
            end else begin
              r_addr <= r_addr + 23'd1;
            end
          end else begin
            if (r_addr == START_ADDR) begin
              r_addr <= END_ADDR;
              r_wrap <= 1'b1;
            end else begin
              r_addr <= r_addr - 23'd1;
            end
          end
        end
        default: r_pend <= 1'b0;
      endcase
    end
  end

  assign ready         = r_ready;
  assign flash_address = r_addr;
  assign busy          = r_busy;
  assign wrap          = r_wrap;
  assign overrun       = r_overrun;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_song_addr_ctrl.sv
// Directed bench for song_addr_ctrl: expected values are hand-derived constants.
module tb_song_addr_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        play;
  logic        forward;
  logic        restart;
  logic        byte_done;
  logic        ready;
  logic [22:0] flash_address;
  logic        busy;
  logic        wrap;
  logic        overrun;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  song_addr_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .play         (play),
    .forward      (forward),
    .restart      (restart),
    .byte_done    (byte_done),
    .ready        (ready),
    .flash_address(flash_address),
    .busy         (busy),
    .wrap         (wrap),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch: tick, then respond/perturb at given cycle offsets after ready (-1 = never)
  task automatic run_fetch(input int bd_delay, input int tick2_at, input int restart_at,
                           input bit with_restart, input bit drop_play,
                           output logic [22:0] a, output int readies, output int wraps,
                           output int to_at);
    bit seen;
    int since;
    seen = 1'b0; since = 0; readies = 0; wraps = 0; to_at = -1; a = 23'h7FFFFF;
    sample_tick = 1'b1;
    restart = with_restart;
    step();
    sample_tick = 1'b0;
    restart = 1'b0;
    if (drop_play) play = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (ready) begin
        readies++;
        a = flash_address;
        seen = 1'b1;
      end
      if (wrap) wraps++;
      if (timeout_err && to_at < 0) to_at = since;
      if (!busy) break;
      byte_done   = seen && (since == bd_delay);
      sample_tick = seen && (since == tick2_at);
      restart     = seen && (since == restart_at);
      if (seen) since++;
      step();
    end
    byte_done = 1'b0;
    sample_tick = 1'b0;
    restart = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_bound: busy=%b after 400 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (flash_address !== 23'h000000) begin n_err++; $display("FAIL reset_addr: got %h required 000000", flash_address); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b required 0", wrap); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b required 0", timeout_err); end
  endtask

  task automatic test_forward();
    logic [22:0] a; int r, w, t;
    play = 1'b1; forward = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_fetch(3, -1, -1, 1'b0, (i == 3), a, r, w, t);
      n_cmp++; if (a !== 23'(i)) begin n_err++; $display("FAIL fwd_addr%0d: got %h required %h", i, a, 23'(i)); end
      n_cmp++; if (r !== 1) begin n_err++; $display("FAIL fwd_ready%0d: got %0d pulses required 1", i, r); end
      n_cmp++; if (w !== 0) begin n_err++; $display("FAIL fwd_wrap%0d: got %0d required 0", i, w); end
      repeat (1128) step();
    end
    n_cmp++; if (flash_address !== 23'd4) begin n_err++; $display("FAIL fwd_final: got %h required 000004", flash_address); end
  endtask

  task automatic test_paused_and_ignored();
    play = 1'b0;
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL paused_busy: got %b required 0", busy); end
    byte_done = 1'b1; step(); byte_done = 1'b0; step();
    n_cmp++; if (flash_address !== 23'd4) begin n_err++; $display("FAIL idle_byte_done: got %h required 000004", flash_address); end
    play = 1'b1;
  endtask

  task automatic test_wrap();
    logic [22:0] a; int r, w, t;
    forward = 1'b1; restart = 1'b1; step(); restart = 1'b0;
    n_cmp++; if (flash_address !== 23'd0) begin n_err++; $display("FAIL restart_idle: got %h required 000000", flash_address); end
    forward = 1'b0;
    run_fetch(3, -1, -1, 1'b0, 1'b0, a, r, w, t);
    n_cmp++; if (flash_address !== 23'h07FFFF) begin n_err++; $display("FAIL rev_wrap_addr: got %h required 07ffff", flash_address); end
    n_cmp++; if (w !== 1) begin n_err++; $display("FAIL rev_wrap_pulse: got %0d required 1", w); end
    forward = 1'b1;
    run_fetch(3, -1, -1, 1'b0, 1'b0, a, r, w, t);
    n_cmp++; if (a !== 23'h07FFFF) begin n_err++; $display("FAIL fwd_wrap_fetch: got %h required 07ffff", a); end
    n_cmp++; if (flash_address !== 23'd0) begin n_err++; $display("FAIL fwd_wrap_addr: got %h required 000000", flash_address); end
    n_cmp++; if (w !== 1) begin n_err++; $display("FAIL fwd_wrap_pulse: got %0d required 1", w); end
  endtask

  task automatic test_restart_with_tick();
    logic [22:0] a; int r, w, t;
    forward = 1'b0;
    run_fetch(3, -1, -1, 1'b1, 1'b0, a, r, w, t);
    n_cmp++; if (a !== 23'h07FFFF) begin n_err++; $display("FAIL restart_tick_fetch: got %h required 07ffff", a); end
    n_cmp++; if (flash_address !== 23'h07FFFE) begin n_err++; $display("FAIL restart_tick_next: got %h required 07fffe", flash_address); end
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL restart_tick_wrap: got %0d required 0", w); end
  endtask

  task automatic test_timeout();
    logic [22:0] a; int r, w, t;
    forward = 1'b1; restart = 1'b1; step(); restart = 1'b0;
    run_fetch(-1, -1, -1, 1'b0, 1'b0, a, r, w, t);
    n_cmp++; if (t !== 256) begin n_err++; $display("FAIL timeout_cycle: flag seen %0d cycles after ready, required 256", t); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b required 1", timeout_err); end
    n_cmp++; if (flash_address !== 23'd1) begin n_err++; $display("FAIL timeout_addr: got %h required 000001", flash_address); end
  endtask

  task automatic test_overrun();
    logic [22:0] a; int r, w, t;
    run_fetch(3, 1, -1, 1'b0, 1'b0, a, r, w, t);
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag: got %b required 1", overrun); end
    n_cmp++; if (r !== 1) begin n_err++; $display("FAIL overrun_ready: got %0d pulses required 1", r); end
    n_cmp++; if (flash_address !== 23'd2) begin n_err++; $display("FAIL overrun_addr: got %h required 000002", flash_address); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
  endtask

  task automatic test_restart_mid();
    logic [22:0] a; int r, w, t;
    restart = 1'b1; step(); restart = 1'b0;
    for (int i = 0; i < 100; i++) run_fetch(1, -1, -1, 1'b0, 1'b0, a, r, w, t);
    n_cmp++; if (flash_address !== 23'd100) begin n_err++; $display("FAIL reach_100: got %h required 000064", flash_address); end
    run_fetch(3, -1, 2, 1'b0, 1'b0, a, r, w, t);
    n_cmp++; if (a !== 23'd100) begin n_err++; $display("FAIL mid_fetch_addr: got %h required 000064", a); end
    n_cmp++; if (flash_address !== 23'd0) begin n_err++; $display("FAIL mid_restart_addr: got %h required 000000", flash_address); end
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL mid_restart_wrap: got %0d required 0", w); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b required 1", overrun); end
  endtask

  task automatic test_async_reset();
    logic [22:0] a; int r, w, t;
    run_fetch(3, -1, -1, 1'b0, 1'b0, a, r, w, t);
    sample_tick = 1'b1; step(); sample_tick = 1'b0; step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy: got %b required 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b required 0", busy); end
    n_cmp++; if (flash_address !== 23'd0) begin n_err++; $display("FAIL areset_addr: got %h required 000000", flash_address); end
    n_cmp++; if (overrun !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL areset_flags: got %b%b required 00", overrun, timeout_err); end
    step(); reset_n = 1'b1; step();
    run_fetch(3, -1, -1, 1'b0, 1'b0, a, r, w, t);
    n_cmp++; if (a !== 23'd0 || r !== 1) begin n_err++; $display("FAIL post_reset_fetch: got addr %h readies %0d required 000000 / 1", a, r); end
    n_cmp++; if (flash_address !== 23'd1) begin n_err++; $display("FAIL post_reset_addr: got %h required 000001", flash_address); end
  endtask

  initial begin
    reset_n = 1'b0; sample_tick = 1'b0; play = 1'b0; forward = 1'b1;
    restart = 1'b0; byte_done = 1'b0;
    repeat (3) step();
    test_reset();
    reset_n = 1'b1;
    step();
    test_forward();
    test_paused_and_ignored();
    test_wrap();
    test_restart_with_tick();
    test_timeout();
    test_overrun();
    test_restart_mid();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
